// File: rtl/mmio_pkg.sv
// Shared types and address-map helpers for the mmio_bank I/O window.
package mmio_pkg;

  localparam int unsigned MMIO_ADDR_W = 16;

  typedef enum logic [1:0] {PORT, STATUS, MASK, NONE} mmio_reg_e;

  function automatic int unsigned MMIO_STATUS_OFS(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned MMIO_MASK_OFS(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/mmio_in_sync.sv
// Two-flop input synchroniser for one port; with MMIO_CHANGE_DETECT_EN it also
// keeps the previous synchronised value and flags a change.
module mmio_in_sync #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync
`ifdef MMIO_CHANGE_DETECT_EN
  ,
  output logic             changed
`endif
);

  logic [WIDTH-1:0] s1, s2;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign sync = s2;

`ifdef MMIO_CHANGE_DETECT_EN
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) prev <= '0;
    else          prev <= s2;
  end

  // High for exactly the cycle in which s2 differs from its previous value.
  assign changed = (s2 != prev);
`endif

endmodule

// File: rtl/mmio_bank.sv
// Memory-mapped I/O bank: NUM_PORTS synchronised inputs, NUM_PORTS output
// registers and, with MMIO_CHANGE_DETECT_EN, sticky change STATUS + MASK + irq_L.
module mmio_bank
  import mmio_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_PORTS = 4,
  parameter logic [15:0] BASE_ADDR = 16'h2000
) (
  input  logic                       clock,
  input  logic                       reset_L,
  input  logic [15:0]                memAddr,
  input  logic                       re_L,
  input  logic                       we_L,
  input  logic [WIDTH-1:0]           wrData,
  input  logic [NUM_PORTS*WIDTH-1:0] portIn,
  output logic [NUM_PORTS*WIDTH-1:0] portOut,
  output logic [WIDTH-1:0]           rdData,
  output logic                       rdDrive_L,
  output logic                       irq_L
);

`ifdef MMIO_CHANGE_DETECT_EN
  localparam int unsigned WIN = NUM_PORTS + 2;
`else
  localparam int unsigned WIN = NUM_PORTS;
`endif

  logic [MMIO_ADDR_W-1:0]     offset;
  logic                       in_win;
  logic                       rd_drive;
  mmio_reg_e                  reg_sel;
  logic [WIDTH-1:0]           rd_val;
  logic [NUM_PORTS*WIDTH-1:0] port_sync;
  logic [NUM_PORTS*WIDTH-1:0] port_out_q;

`ifdef MMIO_CHANGE_DETECT_EN
  logic [NUM_PORTS-1:0] changed;
  logic [NUM_PORTS-1:0] status_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic [NUM_PORTS-1:0] status_clr;
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    mmio_in_sync #(.WIDTH(WIDTH)) u_sync (
      .clock   (clock),
      .reset_L (reset_L),
      .din     (portIn[g*WIDTH +: WIDTH]),
      .sync    (port_sync[g*WIDTH +: WIDTH])
`ifdef MMIO_CHANGE_DETECT_EN
      ,
      .changed (changed[g])
`endif
    );
  end

  // Address decode
  assign offset = memAddr - BASE_ADDR;
  assign in_win = (memAddr >= BASE_ADDR) && (offset < 16'(WIN));

  always_comb begin
    reg_sel = NONE;
    if (in_win) begin
      if (offset < 16'(NUM_PORTS)) reg_sel = PORT;
`ifdef MMIO_CHANGE_DETECT_EN
      else if (offset == 16'(MMIO_STATUS_OFS(NUM_PORTS))) reg_sel = STATUS;
      else if (offset == 16'(MMIO_MASK_OFS(NUM_PORTS)))   reg_sel = MASK;
`endif
    end
  end

  // Read mux; drive is gated by reset so outputs fall back to idle without a clock
  assign rd_drive = reset_L && !re_L && (reg_sel != NONE);

  always_comb begin
    rd_val = '0;
    if (reg_sel == PORT) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (offset == 16'(i)) rd_val = port_sync[i*WIDTH +: WIDTH];
      end
    end
`ifdef MMIO_CHANGE_DETECT_EN
    if (reg_sel == STATUS) rd_val[NUM_PORTS-1:0] = status_q;
    if (reg_sel == MASK)   rd_val[NUM_PORTS-1:0] = mask_q;
`endif
  end

  assign rdData    = rd_drive ? rd_val : '0;
  assign rdDrive_L = !rd_drive;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      port_out_q <= '0;
    end else if (!we_L && reg_sel == PORT) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (offset == 16'(i)) port_out_q[i*WIDTH +: WIDTH] <= wrData;
      end
    end
  end

  assign portOut = port_out_q;

`ifdef MMIO_CHANGE_DETECT_EN
  // Clear sources: any STATUS read, plus write-1-to-clear bits
  always_comb begin
    status_clr = '0;
    if (reg_sel == STATUS) begin
      if (!re_L) status_clr = '1;
      if (!we_L) status_clr = status_clr | wrData[NUM_PORTS-1:0];
    end
  end

  // New change events are OR-ed in after clearing so a coincident set wins
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      status_q <= '0;
      mask_q   <= '0;
    end else begin
      status_q <= (status_q & ~status_clr) | changed;
      if (!we_L && reg_sel == MASK) mask_q <= wrData[NUM_PORTS-1:0];
    end
  end

  assign irq_L = ~|(status_q & mask_q);
`else
  assign irq_L = 1'b1;
`endif

endmodule

// File: tb/tb_mmio_bank.sv
// Scoreboard bench for mmio_bank: a history-based model predicts every cycle's
// outputs; a negedge monitor pops and compares them.
module tb_mmio_bank;

`ifdef MMIO_CHANGE_DETECT_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif
  localparam int NP  = 4;
  localparam int WIN = CD ? NP + 2 : NP;

  logic        clock = 1'b0;
  logic        reset_L;
  logic [15:0] memAddr;
  logic        re_L, we_L;
  logic [15:0] wrData;
  logic [63:0] portIn;
  logic [63:0] portOut;
  logic [15:0] rdData;
  logic        rdDrive_L;
  logic        irq_L;

  mmio_bank #(.WIDTH(16), .NUM_PORTS(NP), .BASE_ADDR(16'h2000)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .memAddr   (memAddr),
    .re_L      (re_L),
    .we_L      (we_L),
    .wrData    (wrData),
    .portIn    (portIn),
    .portOut   (portOut),
    .rdData    (rdData),
    .rdDrive_L (rdDrive_L),
    .irq_L     (irq_L)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        drive_l;
    logic [15:0] data;
    logic        irq_l;
    logic [63:0] pout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Model state: input history (oldest first), last cycle's synchronised view,
  // output registers, sticky flags and mask.
  logic [63:0] hist[$];
  logic [63:0] prev_sync;
  logic [63:0] m_out;
  logic [3:0]  m_status, m_mask;
  logic [63:0] cur_pin;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(64'h0);
    hist.push_back(64'h0);
    prev_sync = '0;
    m_out     = '0;
    m_status  = '0;
    m_mask    = '0;
  endtask

  // One bus cycle: drive, predict, advance the model across the closing edge.
  task automatic step(input logic [15:0] a, input bit rd, input bit wr, input logic [15:0] wd);
    exp_t        e;
    logic [63:0] sync;
    logic [3:0]  chg, clr;
    int          ofs;
    bit          hit;
    memAddr = a; re_L = !rd; we_L = !wr; wrData = wd; portIn = cur_pin;
    sync = hist[0];
    ofs  = int'(a) - 32'h2000;
    hit  = (ofs >= 0) && (ofs < WIN);
    e.drive_l = !(rd && hit);
    e.data    = '0;
    if (rd && hit) begin
      if (ofs < NP)       e.data = sync[ofs*16 +: 16];
      else if (ofs == NP) e.data = {12'h0, m_status};
      else                e.data = {12'h0, m_mask};
    end
    e.irq_l = CD ? !(|(m_status & m_mask)) : 1'b1;
    e.pout  = m_out;
    exp_q.push_back(e);
    clr = '0;
    if (wr && hit) begin
      if (ofs < NP)       m_out[ofs*16 +: 16] = wd;
      else if (ofs == NP) clr = wd[3:0];
      else                m_mask = wd[3:0];
    end
    if (rd && hit && ofs == NP) clr = 4'hF;
    for (int i = 0; i < NP; i++) chg[i] = (sync[i*16 +: 16] != prev_sync[i*16 +: 16]);
    if (CD) m_status = (m_status & ~clr) | chg;
    prev_sync = sync;
    void'(hist.pop_front());
    hist.push_back(cur_pin);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0000, 1'b0, 1'b0, 16'h0);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rdDrive_L", 64'(rdDrive_L), 64'(mon_e.drive_l));
      check("rdData",    64'(rdData),    64'(mon_e.data));
      check("irq_L",     64'(irq_L),     64'(mon_e.irq_l));
      check("portOut",   portOut,        mon_e.pout);
    end
  end

  initial begin
    reset_L = 1'b0; memAddr = 16'h2001; re_L = 1'b0; we_L = 1'b1;
    wrData = '0; cur_pin = '0; portIn = '0;
    model_reset();
    #3;
    check("reset_rdDrive_L", 64'(rdDrive_L), 64'h1);
    check("reset_rdData",    64'(rdData),    64'h0);
    check("reset_portOut",   portOut,        64'h0);
    check("reset_irq_L",     64'(irq_L),     64'h1);
    @(negedge clock);
    re_L = 1'b1;
    #1 reset_L = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i <= 6; i++) step(16'h2000 + 16'(i), 1'b1, 1'b0, 16'h0);

    step(16'h2002, 1'b0, 1'b1, 16'hBEEF);
    idle(1);
    step(16'h1FFF, 1'b0, 1'b1, 16'h1234);
    idle(1);

    cur_pin[16 +: 16] = 16'h00A5;
    step(16'h2001, 1'b1, 1'b0, 16'h0);
    step(16'h2001, 1'b1, 1'b0, 16'h0);
    step(16'h2001, 1'b1, 1'b0, 16'h0);
    step(16'h2004, 1'b1, 1'b0, 16'h0);
    step(16'h2004, 1'b1, 1'b0, 16'h0);

    step(16'h2005, 1'b0, 1'b1, 16'h0002);
    cur_pin[16 +: 16] = 16'h005A;
    idle(4);
    step(16'h2004, 1'b0, 1'b1, 16'h0002);
    idle(1);
    cur_pin[48 +: 16] = 16'h7777;
    idle(4);

    step(16'h2005, 1'b1, 1'b1, 16'h000F);
    cur_pin[0 +: 16] = 16'h0001;
    idle(2);
    step(16'h2004, 1'b1, 1'b0, 16'h0);
    step(16'h2004, 1'b1, 1'b0, 16'h0);
    cur_pin[32 +: 16] = 16'hC3C3;
    idle(3);

    memAddr = 16'h2001; re_L = 1'b0; we_L = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    check("midreset_rdDrive_L", 64'(rdDrive_L), 64'h1);
    check("midreset_rdData",    64'(rdData),    64'h0);
    check("midreset_portOut",   portOut,        64'h0);
    check("midreset_irq_L",     64'(irq_L),     64'h1);
    @(negedge clock);
    re_L = 1'b1; cur_pin = '0; portIn = '0;
    model_reset();
    #1 reset_L = 1'b1;
    @(posedge clock);
    #1;

    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 16'h2000 + 16'(r);
      else if (r == 8) a = 16'h1FFF;
      else             a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        int unsigned p;
        p = $urandom_range(0, NP - 1);
        cur_pin[p*16 +: 16] = 16'($urandom);
      end
      step(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 16'($urandom));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
